// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types, key map and column-pattern helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} kp_state_t;

    // Indexed [row][col]; column 0 is col bit 0.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // True when exactly one active-low column is asserted.
    function automatic logic onehot0_cold(input logic [3:0] col);
        logic [3:0] w_low;
        w_low = ~col;
        return (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] cold_idx(input logic [3:0] col);
        logic [1:0] w_idx;
        case (col)
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
        return w_idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous inputs, resettable to an idle value.
module sync2 #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: one-cold row drive, press/release debounce,
// single-cycle accept pulse and a two-digit history for the display mux.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] r_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] INSPECT_AT = SW'(3);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    kp_state_t     r_state;
    logic [1:0]    r_row;
    logic [SW-1:0] r_scan_cnt;
    logic [DW-1:0] r_deb_cnt;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_col_pat;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic [3:0]    r_digit_new;
    logic [3:0]    r_digit_old;

    logic [3:0]    w_colS;
    logic          w_inspect;
    logic          w_scan_wrap;
    logic          w_lat_high;

    sync2 #(.W(4), .RST_VAL(4'hF)) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (col),
        .o_q   (w_colS)
    );

    // The first scan slots of a row still carry the previous row's columns
    // through the synchronizer, so only late slots are trusted.
    assign w_inspect   = (r_scan_cnt >= INSPECT_AT);
    assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
    assign w_lat_high  = w_colS[r_col_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCAN;
            r_row       <= 2'd0;
            r_scan_cnt  <= '0;
            r_deb_cnt   <= '0;
            r_col_idx   <= 2'd0;
            r_col_pat   <= 4'hF;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_digit_new <= 4'h0;
            r_digit_old <= 4'h0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (w_inspect && onehot0_cold(w_colS)) begin
                        r_col_pat <= w_colS;
                        r_col_idx <= cold_idx(w_colS);
                        r_deb_cnt <= '0;
                        r_state   <= PRESS_DB;
                    end else if (w_scan_wrap) begin
                        r_scan_cnt <= '0;
                        r_row      <= r_row + 2'd1;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (w_colS != r_col_pat) begin
                        r_state    <= SCAN;
                        r_row      <= r_row + 2'd1;
                        r_scan_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state     <= HELD;
                        r_key_code  <= KEYMAP[r_row][r_col_idx];
                        r_digit_new <= KEYMAP[r_row][r_col_idx];
                        r_digit_old <= r_digit_new;
                        r_key_valid <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    // Other columns on the frozen row are deliberately ignored.
                    if (w_lat_high) begin
                        r_deb_cnt <= '0;
                        r_state   <= REL_DB;
                    end
                end
                REL_DB: begin
                    if (!w_lat_high) begin
                        r_state <= HELD;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state    <= SCAN;
                        r_row      <= r_row + 2'd1;
                        r_scan_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign r_sel     = ~(4'b0001 << r_row);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == HELD) || (r_state == REL_DB);
    assign digit_new = r_digit_new;
    assign digit_old = r_digit_old;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives col from r_sel;
// accepted keys are checked against a press-level expectation queue.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col;
    logic [3:0]  r_sel;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [3:0]  digit_new;
    logic [3:0]  digit_old;

    logic [15:0] pressed;   // bit r*4+c = key at row r, column c is down
    int          n_chk = 0;
    int          n_err = 0;

    logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

    logic [3:0] got_code[$], got_new[$], got_old[$];
    logic [3:0] exp_code[$], exp_new_q[$], exp_old_q[$];
    logic [3:0] m_new, m_old;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .r_sel     (r_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    always #5 clk = ~clk;

    // Passive matrix: a column is pulled low when a pressed key sits on a driven row.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (r_sel[r] == 1'b0 && pressed[r*4+c]) col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            got_code.push_back(key_code);
            got_new.push_back(digit_new);
            got_old.push_back(digit_old);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input int k);
        exp_code.push_back(km[k]);
        m_old = m_new;
        m_new = km[k];
        exp_new_q.push_back(m_new);
        exp_old_q.push_back(m_old);
    endtask

    task automatic model_reset();
        m_new = 4'h0;
        m_old = 4'h0;
    endtask

    task automatic check_pulses(input string name);
        int n;
        chk($sformatf("%s pulse count", name), got_code.size(), exp_code.size());
        n = (got_code.size() < exp_code.size()) ? got_code.size() : exp_code.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s code[%0d]", name, i), got_code[i], exp_code[i]);
            chk($sformatf("%s new[%0d]", name, i), got_new[i], exp_new_q[i]);
            chk($sformatf("%s old[%0d]", name, i), got_old[i], exp_old_q[i]);
        end
        chk($sformatf("%s digit_new", name), digit_new, m_new);
        chk($sformatf("%s digit_old", name), digit_old, m_old);
        got_code.delete(); got_new.delete(); got_old.delete();
        exp_code.delete(); exp_new_q.delete(); exp_old_q.delete();
    endtask

    task automatic check_reset_vals(input string name);
        chk($sformatf("%s r_sel", name), r_sel, 4'b1110);
        chk($sformatf("%s key_code", name), key_code, 4'h0);
        chk($sformatf("%s key_valid", name), key_valid, 1'b0);
        chk($sformatf("%s key_held", name), key_held, 1'b0);
        chk($sformatf("%s digit_new", name), digit_new, 4'h0);
        chk($sformatf("%s digit_old", name), digit_old, 4'h0);
    endtask

    typedef struct {
        logic        rst;
        logic [15:0] keys;
        logic [3:0]  e_rsel;
        logic        e_valid;
        logic        e_held;
    } vec_t;

    vec_t vt [17];

    initial begin
        int         k;
        int         found;
        logic [3:0] prev;

        // Idle scan after reset: each row is driven for 4 clocks, in order 0..3.
        for (int i = 0; i < 17; i++) begin
            vt[i].rst     = (i == 0);
            vt[i].keys    = 16'h0;
            vt[i].e_rsel  = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
            vt[i].e_valid = 1'b0;
            vt[i].e_held  = 1'b0;
        end

        reset   = 1'b1;
        pressed = 16'h0;
        model_reset();
        tick(3);
        check_reset_vals("reset");

        // 1. idle scanning
        for (int i = 0; i < 17; i++) begin
            reset   = vt[i].rst;
            pressed = vt[i].keys;
            tick(1);
            chk($sformatf("idle[%0d] r_sel", i), r_sel, vt[i].e_rsel);
            chk($sformatf("idle[%0d] key_valid", i), key_valid, vt[i].e_valid);
            chk($sformatf("idle[%0d] key_held", i), key_held, vt[i].e_held);
        end

        // 2. key 1 held for 500 ns
        pressed[0] = 1'b1;
        accept(0);
        tick(50);
        chk("key1 held", key_held, 1'b1);
        chk("key1 code", key_code, 4'h1);
        pressed = 16'h0;
        tick(30);
        chk("key1 released", key_held, 1'b0);
        check_pulses("key1");

        // 3. key 5 then key D
        pressed[5] = 1'b1;  accept(5);  tick(60);
        pressed = 16'h0;    tick(40);
        pressed[15] = 1'b1; accept(15); tick(60);
        pressed = 16'h0;    tick(40);
        check_pulses("5thenD");

        // 4. bouncing key 2, short glitch on key 6, two keys on one row
        pressed[1] = 1'b1; tick(3);
        pressed[1] = 1'b0; tick(3);
        pressed[1] = 1'b1; accept(1); tick(60);
        pressed = 16'h0;   tick(40);
        pressed[6] = 1'b1; tick(5);
        pressed = 16'h0;   tick(30);
        pressed[4] = 1'b1; pressed[5] = 1'b1; tick(60);
        pressed = 16'h0;   tick(30);
        check_pulses("bounce");

        // 5. hold 1, add 3, drop 3, bounce release of 1, release 1
        pressed[0] = 1'b1; accept(0); tick(40);
        pressed[2] = 1'b1; tick(20);
        chk("hold1+3 held", key_held, 1'b1);
        pressed[2] = 1'b0; tick(20);
        pressed[0] = 1'b0; tick(4);
        pressed[0] = 1'b1; tick(20);
        chk("release bounce held", key_held, 1'b1);
        pressed = 16'h0;   tick(30);
        chk("hold1 released", key_held, 1'b0);
        check_pulses("twokey");

        // Randomized presses and sub-debounce glitches
        for (int it = 0; it < 14; it++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                pressed[k] = 1'b1;
                tick($urandom_range(1, 7));
                pressed = 16'h0;
                tick(25);
            end else begin
                pressed[k] = 1'b1;
                accept(k);
                tick($urandom_range(40, 70));
                chk($sformatf("rand[%0d] held", it), key_held, 1'b1);
                pressed = 16'h0;
                tick($urandom_range(30, 50));
                chk($sformatf("rand[%0d] released", it), key_held, 1'b0);
            end
        end
        check_pulses("random");

        // Debounce boundary, aligned to a fresh scan of row 0
        reset = 1'b1; tick(1); reset = 1'b0; model_reset();
        pressed[0] = 1'b1; tick(9);
        pressed = 16'h0;   tick(30);
        check_pulses("glitch9");
        reset = 1'b1; tick(1); reset = 1'b0; model_reset();
        pressed[0] = 1'b1; accept(0); tick(12);
        pressed = 16'h0;   tick(30);
        check_pulses("press12");

        // 6a. reset during PRESS_DB on row 1
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            prev = r_sel;
            tick(1);
            if (prev != 4'b1110 && r_sel == 4'b1110) found = 1;
        end
        chk("align row0", found, 1);
        pressed[5] = 1'b1;
        tick(12);
        chk("press_db r_sel frozen", r_sel, 4'b1101);
        chk("press_db not held", key_held, 1'b0);
        reset = 1'b1;
        tick(1);
        check_reset_vals("rst in press_db");
        model_reset();
        pressed = 16'h0;
        tick(1);
        reset = 1'b0;
        tick(30);
        check_pulses("after rst press_db");

        // 6b. reset during HELD
        pressed[10] = 1'b1; accept(10); tick(50);
        chk("key9 held", key_held, 1'b1);
        check_pulses("key9");
        reset = 1'b1;
        tick(1);
        check_reset_vals("rst in held");
        model_reset();
        pressed = 16'h0;
        tick(1);
        reset = 1'b0;
        tick(30);
        check_pulses("after rst held");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
